// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide upstream TCDM request into MP narrow lane requests and
// reassembles the per-lane responses into a single wide response pulse.
module redmule_tcdm_splitter #(
  parameter int DW      = 256,
  parameter int MP      = 8,
  parameter int AW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_req_i,
  output logic                           in_gnt_o,
  input  logic [AW-1:0]                  in_add_i,
  input  logic                           in_wen_i,
  input  logic [DW/8-1:0]                in_be_i,
  input  logic [DW-1:0]                  in_data_i,
  output logic [DW-1:0]                  in_r_data_o,
  output logic                           in_r_valid_o,
  output logic [MP-1:0]                  tcdm_req_o,
  output logic [MP-1:0][AW-1:0]          tcdm_add_o,
  output logic [MP-1:0]                  tcdm_wen_o,
  output logic [MP-1:0][DW/MP/8-1:0]     tcdm_be_o,
  output logic [MP-1:0][DW/MP-1:0]       tcdm_data_o,
  input  logic [MP-1:0]                  tcdm_gnt_i,
  input  logic [MP-1:0]                  tcdm_r_valid_i,
  input  logic [MP-1:0][DW/MP-1:0]       tcdm_r_data_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int LW = DW / MP;
  localparam int LB = LW / 8;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUT - 1);

  logic [MP-1:0] r_done;
  logic [CW-1:0] r_out;
  logic          r_rvalid;
  logic          r_err;
  logic [CW-1:0] r_pend [MP];
  logic [CW-1:0] r_cnt  [MP];
  logic [PW-1:0] r_wptr [MP];
  logic [PW-1:0] r_rptr [MP];
  logic [LW-1:0] r_mem  [MP][MAX_OUT];

  logic          w_credit;
  logic [MP-1:0] w_lane_gnt;
  logic [MP-1:0] w_resp_ok;
  logic [MP-1:0] w_spur;
  logic [MP-1:0] w_ovf;
  logic [MP-1:0] w_push;
  logic [MP-1:0] w_nonempty_nxt;
  logic [CW-1:0] w_cnt_nxt [MP];

  assign w_credit = (r_out < MAX_C);

  always_comb begin
    tcdm_req_o  = '0;
    tcdm_add_o  = '0;
    tcdm_wen_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int i = 0; i < MP; i++) begin
      tcdm_req_o[i]  = in_req_i & ~r_done[i] & w_credit & ~rst_i;
      tcdm_add_o[i]  = in_add_i + AW'(i * LB);
      tcdm_wen_o[i]  = in_wen_i;
      tcdm_be_o[i]   = in_be_i[i*LB +: LB];
      tcdm_data_o[i] = in_data_i[i*LW +: LW];
    end
  end

  assign w_lane_gnt = tcdm_req_o & tcdm_gnt_i;
  // The wide grant fires in the cycle the last missing lane is granted.
  assign in_gnt_o   = in_req_i & w_credit & (&(r_done | w_lane_gnt));

  always_comb begin
    w_resp_ok      = '0;
    w_spur         = '0;
    w_ovf          = '0;
    w_push         = '0;
    w_nonempty_nxt = '0;
    in_r_data_o    = '0;
    for (int i = 0; i < MP; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end
    for (int i = 0; i < MP; i++) begin
      w_resp_ok[i]      = tcdm_r_valid_i[i] & (r_pend[i] != '0);
      w_spur[i]         = tcdm_r_valid_i[i] & (r_pend[i] == '0);
      w_ovf[i]          = w_resp_ok[i] & (r_cnt[i] == MAX_C) & ~r_rvalid;
      w_push[i]         = w_resp_ok[i] & ~w_ovf[i];
      w_cnt_nxt[i]      = r_cnt[i] + CW'(w_push[i]) - CW'(r_rvalid);
      w_nonempty_nxt[i] = (w_cnt_nxt[i] != '0);
      in_r_data_o[i*LW +: LW] = r_rvalid ? r_mem[i][r_rptr[i]] : '0;
    end
  end

  assign in_r_valid_o = r_rvalid;
  assign err_o        = r_err;
  assign busy_o       = (r_out != '0) | (|r_done);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done   <= '0;
      r_out    <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < MP; i++) begin
        r_pend[i] <= '0;
        r_cnt[i]  <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      if (in_gnt_o) begin
        r_done <= '0;
      end else begin
        r_done <= r_done | w_lane_gnt;
      end
      if (in_gnt_o && !r_rvalid) begin
        r_out <= r_out + CW'(1);
      end else if (!in_gnt_o && r_rvalid && (r_out != '0)) begin
        r_out <= r_out - CW'(1);
      end
      // Registering "all lanes non-empty next cycle" keeps back-to-back pulses gapless.
      r_rvalid <= &w_nonempty_nxt;
      if (|(w_spur | w_ovf)) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < MP; i++) begin
        r_pend[i] <= r_pend[i] + CW'(w_lane_gnt[i]) - CW'(w_resp_ok[i]);
        r_cnt[i]  <= w_cnt_nxt[i];
        if (w_push[i]) begin
          r_wptr[i] <= (r_wptr[i] == LAST_P) ? '0 : r_wptr[i] + PW'(1);
        end
        if (r_rvalid) begin
          r_rptr[i] <= (r_rptr[i] == LAST_P) ? '0 : r_rptr[i] + PW'(1);
        end
      end
    end
  end

  // Response storage carries data only, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= tcdm_r_data_i[i];
      end
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter (DW=128, MP=4, MAX_OUT=2) with a
// queue-based reference model checked every cycle plus literal expectations.
module tb_redmule_tcdm_splitter;

  localparam int DW = 128;
  localparam int MP = 4;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int LW = DW / MP;
  localparam int LB = LW / 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_req = 1'b0;
  logic                   in_wen = 1'b0;
  logic [AW-1:0]          in_add = '0;
  logic [DW/8-1:0]        in_be = '0;
  logic [DW-1:0]          in_data = '0;
  logic [MP-1:0]          gnt = '0;
  logic [MP-1:0]          rvld = '0;
  logic [MP-1:0][LW-1:0]  rdat = '0;

  logic                   in_gnt_o;
  logic [DW-1:0]          in_r_data_o;
  logic                   in_r_valid_o;
  logic [MP-1:0]          tcdm_req_o;
  logic [MP-1:0][AW-1:0]  tcdm_add_o;
  logic [MP-1:0]          tcdm_wen_o;
  logic [MP-1:0][LB-1:0]  tcdm_be_o;
  logic [MP-1:0][LW-1:0]  tcdm_data_o;
  logic                   busy_o;
  logic                   err_o;

  int checks = 0;
  int failures = 0;

  redmule_tcdm_splitter #(.DW(DW), .MP(MP), .AW(AW), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(in_req), .in_gnt_o(in_gnt_o),
    .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be), .in_data_i(in_data),
    .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_gnt_i(gnt), .tcdm_r_valid_i(rvld), .tcdm_r_data_i(rdat),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lane bookkeeping as sets/counters, lane buffers as queues.
  bit   [MP-1:0] m_done;
  int            m_out;
  int            m_pend [MP];
  logic [LW-1:0] m_q [MP][$];
  bit            m_err;

  always @(negedge clk) begin : model
    logic [MP-1:0]         req_e;
    logic [MP-1:0]         lg;
    logic                  gnt_e;
    logic                  rv_e;
    logic [DW-1:0]         rd_e;
    logic [MP-1:0][AW-1:0] add_e;
    bit                    full_pre [MP];
    if (rst) begin
      chk("rst_tcdm_req", 128'(tcdm_req_o), 128'(0));
      chk("rst_in_gnt", 128'(in_gnt_o), 128'(0));
      chk("rst_r_valid", 128'(in_r_valid_o), 128'(0));
      chk("rst_r_data", 128'(in_r_data_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_err", 128'(err_o), 128'(0));
      m_done = '0;
      m_out  = 0;
      m_err  = 1'b0;
      for (int i = 0; i < MP; i++) begin
        m_pend[i] = 0;
        m_q[i].delete();
      end
    end else begin
      for (int i = 0; i < MP; i++) begin
        req_e[i] = in_req && !m_done[i] && (m_out < MO);
        lg[i]    = req_e[i] && gnt[i];
        add_e[i] = in_add + 32'(i * LB);
      end
      gnt_e = in_req && (m_out < MO) && ((m_done | lg) == {MP{1'b1}});
      rv_e  = 1'b1;
      for (int i = 0; i < MP; i++) if (m_q[i].size() == 0) rv_e = 1'b0;
      rd_e = '0;
      if (rv_e) for (int i = 0; i < MP; i++) rd_e[i*LW +: LW] = m_q[i][0];

      chk("m_tcdm_req", 128'(tcdm_req_o), 128'(req_e));
      chk("m_in_gnt", 128'(in_gnt_o), 128'(gnt_e));
      chk("m_tcdm_add", 128'(tcdm_add_o), 128'(add_e));
      chk("m_tcdm_wen", 128'(tcdm_wen_o), 128'({MP{in_wen}}));
      chk("m_tcdm_be", 128'(tcdm_be_o), 128'(in_be));
      chk("m_tcdm_data", 128'(tcdm_data_o), 128'(in_data));
      chk("m_r_valid", 128'(in_r_valid_o), 128'(rv_e));
      chk("m_r_data", 128'(in_r_data_o), 128'(rd_e));
      chk("m_err", 128'(err_o), 128'(m_err));
      chk("m_busy", 128'(busy_o), 128'((m_out != 0) || (m_done != '0)));

      for (int i = 0; i < MP; i++) full_pre[i] = (m_q[i].size() >= MO);
      if (rv_e) for (int i = 0; i < MP; i++) void'(m_q[i].pop_front());
      for (int i = 0; i < MP; i++) begin
        if (rvld[i]) begin
          if (m_pend[i] == 0) begin
            m_err = 1'b1;
          end else begin
            m_pend[i]--;
            if (full_pre[i] && !rv_e) m_err = 1'b1;
            else m_q[i].push_back(rdat[i]);
          end
        end
        if (lg[i]) m_pend[i]++;
      end
      if (gnt_e) m_done = '0;
      else m_done = m_done | lg;
      m_out = m_out + (gnt_e ? 1 : 0) - (rv_e ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_req = 1'b0;
    gnt    = '0;
    rvld   = '0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_busy", 128'(busy_o), 128'(0));
    chk("post_rst_err", 128'(err_o), 128'(0));

    // All lanes granted at once, read
    tick(); in_req = 1'b1; in_add = 32'h1000; in_wen = 1'b1; in_be = '1;
    in_data = 128'h33333333_22222222_11111111_00000000; gnt = 4'hF;
    @(negedge clk);
    chk("t1_in_gnt", 128'(in_gnt_o), 128'(1));
    chk("t1_add", 128'(tcdm_add_o), 128'h0000100C_00001008_00001004_00001000);
    tick(); idle();
    tick(); rvld = 4'hF; rdat = {32'hA0A00003, 32'hA0A00002, 32'hA0A00001, 32'hA0A00000};
    tick(); rvld = '0;
    @(negedge clk);
    chk("t1_r_valid", 128'(in_r_valid_o), 128'(1));
    chk("t1_r_data", 128'(in_r_data_o), 128'hA0A00003_A0A00002_A0A00001_A0A00000);
    tick();
    @(negedge clk);
    chk("t1_r_valid_pulse", 128'(in_r_valid_o), 128'(0));

    // Staggered grants, write
    tick(); in_req = 1'b1; in_add = 32'h2000; in_wen = 1'b0; in_be = 16'h0F3C;
    in_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; gnt = 4'b0001;
    @(negedge clk);
    chk("t2_req_c0", 128'(tcdm_req_o), 128'hF);
    chk("t2_gnt_c0", 128'(in_gnt_o), 128'(0));
    tick(); gnt = 4'b0110;
    @(negedge clk);
    chk("t2_req_c1", 128'(tcdm_req_o), 128'hE);
    chk("t2_gnt_c1", 128'(in_gnt_o), 128'(0));
    tick(); gnt = 4'b0000;
    @(negedge clk);
    chk("t2_req_c2", 128'(tcdm_req_o), 128'h8);
    tick(); gnt = 4'b1000;
    @(negedge clk);
    chk("t2_req_c3", 128'(tcdm_req_o), 128'h8);
    chk("t2_gnt_c3", 128'(in_gnt_o), 128'(1));
    tick(); idle();
    @(negedge clk);
    chk("t2_busy", 128'(busy_o), 128'(1));
    tick(); rvld = 4'hF; rdat = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    tick(); rvld = '0;
    @(negedge clk);
    chk("t2_r_valid", 128'(in_r_valid_o), 128'(1));
    tick();

    // Skewed responses: lane 2 three cycles late
    tick(); in_req = 1'b1; in_add = 32'h3000; in_wen = 1'b1; gnt = 4'hF;
    tick(); idle();
    tick(); rvld = 4'b1011; rdat = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    tick(); rvld = '0;
    @(negedge clk);
    chk("t3_no_valid_c3", 128'(in_r_valid_o), 128'(0));
    tick();
    tick(); rvld = 4'b0100;
    @(negedge clk);
    chk("t3_no_valid_c5", 128'(in_r_valid_o), 128'(0));
    tick(); rvld = '0;
    @(negedge clk);
    chk("t3_r_valid", 128'(in_r_valid_o), 128'(1));
    chk("t3_r_data", 128'(in_r_data_o), 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    tick();
    @(negedge clk);
    chk("t3_single_pulse", 128'(in_r_valid_o), 128'(0));

    // Credit limit with three back-to-back reads
    tick(); in_req = 1'b1; in_add = 32'h4000; in_wen = 1'b1; gnt = 4'hF;
    @(negedge clk);
    chk("t4_gnt_a", 128'(in_gnt_o), 128'(1));
    tick(); in_add = 32'h4010;
    @(negedge clk);
    chk("t4_gnt_b", 128'(in_gnt_o), 128'(1));
    tick(); in_add = 32'h4020;
    @(negedge clk);
    chk("t4_stall_req", 128'(tcdm_req_o), 128'(0));
    chk("t4_stall_gnt", 128'(in_gnt_o), 128'(0));
    tick(); rvld = 4'hF; rdat = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
    @(negedge clk);
    chk("t4_stall_req_c3", 128'(tcdm_req_o), 128'(0));
    tick(); rvld = '0;
    @(negedge clk);
    chk("t4_pop_a", 128'(in_r_valid_o), 128'(1));
    chk("t4_stall_req_c4", 128'(tcdm_req_o), 128'(0));
    tick();
    @(negedge clk);
    chk("t4_issue_c", 128'(tcdm_req_o), 128'hF);
    chk("t4_gnt_c", 128'(in_gnt_o), 128'(1));
    tick(); idle();
    tick(); rvld = 4'hF; rdat = {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000};
    tick(); rdat = {32'hF0000003, 32'hF0000002, 32'hF0000001, 32'hF0000000};
    @(negedge clk);
    chk("t4_valid_b", 128'(in_r_valid_o), 128'(1));
    chk("t4_data_b", 128'(in_r_data_o), 128'hE0000003_E0000002_E0000001_E0000000);
    tick(); rvld = '0;
    @(negedge clk);
    chk("t4_valid_c", 128'(in_r_valid_o), 128'(1));
    chk("t4_data_c", 128'(in_r_data_o), 128'hF0000003_F0000002_F0000001_F0000000);
    tick();
    @(negedge clk);
    chk("t4_valid_end", 128'(in_r_valid_o), 128'(0));
    chk("t4_busy_end", 128'(busy_o), 128'(0));

    // Address wrap, then a spurious response
    tick(); in_req = 1'b1; in_add = 32'hFFFFFFF8; in_wen = 1'b1; gnt = 4'hF;
    @(negedge clk);
    chk("t5_add_wrap", 128'(tcdm_add_o), 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);
    chk("t5_gnt", 128'(in_gnt_o), 128'(1));
    tick(); idle();
    tick(); rvld = 4'hF; rdat = {32'h5, 32'h4, 32'h3, 32'h2};
    tick(); rvld = '0;
    @(negedge clk);
    chk("t5_r_valid", 128'(in_r_valid_o), 128'(1));
    tick();
    tick(); rvld = 4'b0010; rdat = {32'h0, 32'h0, 32'hBAD, 32'h0};
    @(negedge clk);
    chk("t5_err_before", 128'(err_o), 128'(0));
    tick(); rvld = '0;
    @(negedge clk);
    chk("t5_err_set", 128'(err_o), 128'(1));
    chk("t5_spur_dropped", 128'(in_r_valid_o), 128'(0));
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_sticky", 128'(err_o), 128'(1));

    // Reset in the middle of a partially granted request
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t6_err_cleared", 128'(err_o), 128'(0));
    tick(); rst = 1'b0;
    tick(); in_req = 1'b1; in_add = 32'h6000; in_wen = 1'b1; gnt = 4'b0011;
    @(negedge clk);
    chk("t6_req_c0", 128'(tcdm_req_o), 128'hF);
    tick(); rst = 1'b1; gnt = 4'hF;
    @(negedge clk);
    chk("t6_rst_req", 128'(tcdm_req_o), 128'(0));
    chk("t6_rst_gnt", 128'(in_gnt_o), 128'(0));
    chk("t6_rst_busy", 128'(busy_o), 128'(0));
    tick(); rst = 1'b0; gnt = '0; rvld = 4'b0001; rdat = {32'h0, 32'h0, 32'h0, 32'h77};
    @(negedge clk);
    chk("t6_reissue_all", 128'(tcdm_req_o), 128'hF);
    chk("t6_err_c2", 128'(err_o), 128'(0));
    tick(); rvld = '0; gnt = 4'hF;
    @(negedge clk);
    chk("t6_late_resp_err", 128'(err_o), 128'(1));
    chk("t6_gnt", 128'(in_gnt_o), 128'(1));
    tick(); idle();
    tick(); rvld = 4'hF; rdat = {32'h63, 32'h62, 32'h61, 32'h60};
    tick(); rvld = '0;
    @(negedge clk);
    chk("t6_r_valid", 128'(in_r_valid_o), 128'(1));
    chk("t6_r_data", 128'(in_r_data_o), 128'h00000063_00000062_00000061_00000060);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_splitter.md
REDMULE_TCDM_SPLITTER -- requirements
Module: redmule_tcdm_splitter

Interface
REQ-001 The block SHALL have parameter DW, default 256: wide upstream data width in bits.
REQ-002 The block SHALL have parameter MP, default 8: number of narrow TCDM lanes; DW SHALL be divisible by MP*8.
REQ-003 The block SHALL have parameter AW, default 32: address width.
REQ-004 The block SHALL have parameter MAX_OUT, default 4: maximum outstanding wide transactions and per-lane response FIFO depth.
REQ-005 The block SHALL use LW = DW/MP as the lane data width and LB = LW/8 as the lane byte count.
REQ-006 The block SHALL have port clk_i, input, 1: the single clock.
REQ-007 The block SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-008 The block SHALL have port in_req_i, input, 1: upstream wide request.
REQ-009 The block SHALL have port in_gnt_o, output, 1: upstream grant.
REQ-010 The block SHALL have ports in_add_i [AW], in_wen_i [1] (1 = read), in_be_i [DW/8] and in_data_i [DW], all inputs: the upstream request payload.
REQ-011 The block SHALL have port in_r_data_o, output, DW: reassembled response data.
REQ-012 The block SHALL have port in_r_valid_o, output, 1: wide response valid.
REQ-013 The block SHALL have ports tcdm_req_o [MP], tcdm_add_o [MP][AW], tcdm_wen_o [MP], tcdm_be_o [MP][LB] and tcdm_data_o [MP][LW], all outputs: narrow lane requests.
REQ-014 The block SHALL have ports tcdm_gnt_i [MP], tcdm_r_valid_i [MP] and tcdm_r_data_i [MP][LW], all inputs: narrow lane grants and responses.
REQ-015 The block SHALL have port busy_o, output, 1: transaction in flight.
REQ-016 The block SHALL have port err_o, output, 1: sticky protocol error.

Function
REQ-017 Lane i payload SHALL be: add = in_add_i + i*LB (modulo 2^AW); be/data = slice i of in_be_i/in_data_i, with lane 0 at the LSBs; wen = in_wen_i.
REQ-018 A register done[MP] SHALL record lanes already granted for the current upstream request.
REQ-019 tcdm_req_o[i] SHALL be in_req_i & ~done[i] & (outstanding < MAX_OUT) & ~rst_i.
REQ-020 Lanes SHALL be granted independently and in any cycle order; done[i] SHALL set on tcdm_req_o[i] & tcdm_gnt_i[i].
REQ-021 in_gnt_o SHALL be combinational: in_req_i & (outstanding < MAX_OUT) & AND over i of (done[i] | (tcdm_req_o[i] & tcdm_gnt_i[i])).
REQ-022 On in_gnt_o, done SHALL clear to 0 in the next cycle.
REQ-023 The upstream SHALL hold its payload stable while in_req_i & ~in_gnt_o; the block SHALL not re-issue lanes marked in done.
REQ-024 The outstanding counter (width clog2(MAX_OUT+1)) SHALL be +1 on in_gnt_o, -1 on in_r_valid_o, and unchanged when both occur in the same cycle.
REQ-025 When outstanding == MAX_OUT, all tcdm_req_o and in_gnt_o SHALL be 0; a later pop SHALL re-enable them.
REQ-026 Every granted lane request, read or write, SHALL return exactly one tcdm_r_valid_i, in order per lane.
REQ-027 Each lane SHALL push tcdm_r_data_i into its own FIFO of depth MAX_OUT.
REQ-028 Lane responses for one wide transaction MAY arrive in different cycles.
REQ-029 in_r_valid_o SHALL be registered: asserted the cycle after all lane FIFOs are non-empty, equivalently 1 cycle after the last lane response.
REQ-030 in_r_valid_o SHALL be a 1-cycle pulse per wide transaction that pops all FIFOs simultaneously.
REQ-031 Back-to-back wide responses SHALL produce consecutive pulses with no bubble.
REQ-032 in_r_data_o SHALL be the concatenation of the FIFO heads (lane 0 at the LSBs), held while in_r_valid_o is asserted, and 0 otherwise.
REQ-033 A push and a pop on the same lane in the same cycle SHALL be legal, including when the FIFO is full.
REQ-034 err_o SHALL set on tcdm_r_valid_i[i] with lane FIFO i full and no pop in that cycle.
REQ-035 err_o SHALL set on tcdm_r_valid_i[i] when lane i has no unanswered grant; the offending data SHALL be dropped.
REQ-036 err_o SHALL clear only on reset.
REQ-037 busy_o SHALL be (outstanding != 0) | (|done).

Reset
REQ-038 While rst_i is asserted, done, outstanding, FIFO pointers, in_r_valid_o and err_o SHALL be 0; tcdm_req_o, in_gnt_o and busy_o SHALL be 0.
REQ-039 Reset mid-transaction SHALL discard partial grants and buffered responses.
REQ-040 Lane responses arriving after reset release for pre-reset grants SHALL set err_o.

Verification (DW=128, MP=4, AW=32, MAX_OUT=2)
REQ-041 All-grant read: add 0x1000, all gnt=1 in cycle 0, all r_valid in cycle 2 -> in_gnt_o in cycle 0; lane addresses 0x1000/0x1004/0x1008/0x100C; in_r_valid_o in cycle 3 with correctly ordered data.
REQ-042 Staggered grants: lanes granted in cycles 0, 1, 1, 3 -> each lane requested until its grant and never re-requested; in_gnt_o only in cycle 3.
REQ-043 Skewed responses: lane 2 responds 3 cycles after the others -> exactly one in_r_valid_o, 1 cycle after lane 2's response, with full 128-bit data.
REQ-044 Credit limit: 3 back-to-back reads with responses held back -> third request stalls with tcdm_req_o=0; it issues the cycle after the first pop; outstanding never exceeds 2.
REQ-045 Wrap and error: add 0xFFFFFFF8 -> lanes at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; a spurious r_valid on lane 1 while idle -> err_o=1 stays set until rst_i.
REQ-046 Reset after 2 of 4 lanes granted -> all outputs 0 during reset; next request after release issues all 4 lanes.
